// File: rtl/disp_pkg.sv
// Shared types and constants for the HEX7..HEX0 display scheduler.
package disp_pkg;
   typedef enum logic [1:0] {IDLE, OWN, GAP} state_e;

   localparam int             DIGITS      = 8;
   localparam int             FRAME_W     = 56;
   localparam logic [6:0]     SEG_BLANK   = 7'h7F;
   localparam logic [FRAME_W-1:0] FRAME_BLANK = {DIGITS{SEG_BLANK}};
endpackage

// File: rtl/hex_display_sched_rr_pick.sv
// Round-robin search: first set request at or above start, wrapping modulo NREQ.
module rr_pick #(
   parameter int NREQ = 3,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  start,
   output logic            valid,
   output logic [IDW-1:0]  idx
);
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!valid && req[(int'(start) + k) % NREQ]) begin
            valid = 1'b1;
            idx   = IDW'((int'(start) + k) % NREQ);
         end
      end
   end
endmodule

// File: rtl/hex_display_sched.sv
// Time-slice scheduler granting the HEX bank to one source at a time,
// with minimum hold, maximum slice and an optional blank gap between owners.
module hex_display_sched
   import disp_pkg::*;
#(
   parameter int NREQ        = 3,
   parameter int HOLD_TICKS  = 2,
   parameter int SLICE_TICKS = 4,
   parameter int GAP_TICKS   = 1,
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    tick,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*FRAME_W-1:0] seg_in,
   output logic [FRAME_W-1:0]      hex_out,
   output logic [NREQ-1:0]         grant,
   output logic [IDW-1:0]          owner_id,
   output logic                    switch_pulse
);
   localparam int CMAX  = (SLICE_TICKS > GAP_TICKS) ? SLICE_TICKS : GAP_TICKS;
   localparam int CNT_W = $clog2(CMAX + 1);
   localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD_TICKS);
   localparam logic [CNT_W-1:0] SLICE_C = CNT_W'(SLICE_TICKS);
   localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(GAP_TICKS);

   state_e             state_q, state_d;
   logic [NREQ-1:0]    grant_q, grant_d;
   logic [IDW-1:0]     owner_q, owner_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [FRAME_W-1:0] hex_q, hex_d;
   logic               sw_q, sw_d;

   logic [IDW-1:0]     start, win;
   logic               win_vld, own_req, others, release_own;
   logic [NREQ-1:0]    win_onehot;
   logic [FRAME_W-1:0] own_frame;

   // Starting just past the current owner puts it last in the search order.
   assign start = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + IDW'(1);

   rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_rr_pick (
      .req   (req),
      .start (start),
      .valid (win_vld),
      .idx   (win)
   );

   assign win_onehot  = {{(NREQ-1){1'b0}}, 1'b1} << win;
   assign own_req     = req[owner_q];
   assign own_frame   = seg_in[FRAME_W*owner_q +: FRAME_W];
   assign others      = |(req & ~grant_q);
   assign release_own = (!own_req && cnt_q >= HOLD_C) || (cnt_q == SLICE_C && others);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      hex_d   = hex_q;
      sw_d    = 1'b0;
      case (state_q)
         IDLE: begin
            hex_d   = FRAME_BLANK;
            grant_d = '0;
            cnt_d   = '0;
            if (win_vld) begin
               state_d = OWN;
               grant_d = win_onehot;
               owner_d = win;
               sw_d    = 1'b1;
            end
         end
         OWN: begin
            if (own_req) hex_d = own_frame;
            // sw_q marks the entry cycle, whose tick is ignored.
            if (tick && !sw_q && cnt_q != SLICE_C) cnt_d = cnt_q + CNT_W'(1);
            if (release_own) begin
               cnt_d = '0;
               if (GAP_TICKS != 0) begin
                  state_d = GAP;
                  grant_d = '0;
                  hex_d   = FRAME_BLANK;
               end else if (win_vld) begin
                  grant_d = win_onehot;
                  owner_d = win;
                  sw_d    = 1'b1;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
                  hex_d   = FRAME_BLANK;
               end
            end
         end
         GAP: begin
            hex_d   = FRAME_BLANK;
            grant_d = '0;
            if (cnt_q >= GAP_C) begin
               cnt_d = '0;
               if (win_vld) begin
                  state_d = OWN;
                  grant_d = win_onehot;
                  owner_d = win;
                  sw_d    = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else if (tick) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         owner_q <= IDW'(NREQ - 1);
         cnt_q   <= '0;
         hex_q   <= FRAME_BLANK;
         sw_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         hex_q   <= hex_d;
         sw_q    <= sw_d;
      end
   end

   assign hex_out      = hex_q;
   assign grant        = grant_q;
   assign owner_id     = owner_q;
   assign switch_pulse = sw_q;
endmodule

// File: tb/tb_hex_display_sched.sv
// Directed bench: one instance with a one-tick gap, one with direct handover.
module tb_hex_display_sched;
   localparam logic [55:0] BLANK = 56'hFF_FFFF_FFFF_FFFF;
   localparam logic [55:0] F0 = 56'h01234567_89ABCD;
   localparam logic [55:0] F1 = 56'h11223344_556677;
   localparam logic [55:0] F2 = 56'h7E7D7B77_6F5F3F;
   localparam logic [55:0] FB = 56'h0;

   logic clk = 1'b0, rst = 1'b1, tick = 1'b0;
   logic [2:0]   req1 = '0, req0 = '0;
   logic [167:0] seg = {F2, F1, F0};
   logic [55:0]  hex1, hex0;
   logic [2:0]   gnt1, gnt0;
   logic [1:0]   id1, id0;
   logic         sw1, sw0;

   int k = 0, checks = 0, failures = 0;

   always #5 clk = ~clk;

   hex_display_sched #(.NREQ(3), .HOLD_TICKS(2), .SLICE_TICKS(4), .GAP_TICKS(1)) dut (
      .clk(clk), .rst(rst), .tick(tick), .req(req1), .seg_in(seg),
      .hex_out(hex1), .grant(gnt1), .owner_id(id1), .switch_pulse(sw1));

   hex_display_sched #(.NREQ(3), .HOLD_TICKS(2), .SLICE_TICKS(4), .GAP_TICKS(0)) dut0 (
      .clk(clk), .rst(rst), .tick(tick), .req(req0), .seg_in(seg),
      .hex_out(hex0), .grant(gnt0), .owner_id(id0), .switch_pulse(sw0));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s (k=%0d): got %0h expected %0h", nm, k, act, exp);
      end
   endtask

   // Outputs sampled after adv() reflect cycle k; inputs set afterwards apply to cycle k.
   task automatic adv();
      @(negedge clk);
      k = k + 1;
      tick = (k % 4 == 3);
   endtask

   // Ends at k=0 with reset state visible and rst released.
   task automatic do_reset(input logic [2:0] r1, input logic [2:0] r0);
      rst = 1'b1;
      adv(); adv();
      k = -1;
      adv();
      rst = 1'b0;
      req1 = r1;
      req0 = r0;
   endtask

   typedef struct {
      logic [2:0]  req;
      logic [2:0]  grant;
      logic [1:0]  id;
      logic [55:0] hex;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int bad, swcnt;
      vecs[0] = '{3'b001, 3'b001, 2'd0, F0};
      vecs[1] = '{3'b010, 3'b010, 2'd1, F1};
      vecs[2] = '{3'b100, 3'b100, 2'd2, F2};
      vecs[3] = '{3'b110, 3'b010, 2'd1, F1};
      vecs[4] = '{3'b101, 3'b001, 2'd0, F0};
      vecs[5] = '{3'b111, 3'b001, 2'd0, F0};

      // Reset state with all requests asserted during reset.
      req1 = 3'b111; req0 = 3'b111;
      adv(); adv();
      chk("rst_hex", hex1, BLANK);
      chk("rst_grant", gnt1, 3'b000);
      chk("rst_sw", sw1, 1'b0);
      chk("rst_id", id1, 2'd2);
      chk("rst_hex_g0", hex0, BLANK);
      chk("rst_grant_g0", gnt0, 3'b000);

      // First grant from IDLE: req[0] has priority after reset.
      for (int v = 0; v < 6; v++) begin
         do_reset(vecs[v].req, 3'b000);
         adv();
         chk("first_grant", gnt1, vecs[v].grant);
         chk("first_sw", sw1, 1'b1);
         chk("first_id", id1, vecs[v].id);
         chk("first_hex_blank", hex1, BLANK);
         adv();
         chk("first_hex", hex1, vecs[v].hex);
         chk("first_sw_drop", sw1, 1'b0);
      end

      // Rotation between two steady requesters.
      do_reset(3'b011, 3'b000);
      bad = 0;
      while (k < 42) begin
         adv();
         if ($countones(gnt1) > 1) bad = 1;
         case (k)
            1:  begin chk("rot_g1", gnt1, 3'b001); chk("rot_sw1", sw1, 1'b1); end
            2:  chk("rot_hex0", hex1, F0);
            16: chk("rot_g16", gnt1, 3'b001);
            17: begin chk("rot_g17", gnt1, 3'b000); chk("rot_gap_hex", hex1, BLANK); end
            20: chk("rot_g20", gnt1, 3'b000);
            21: begin chk("rot_g21", gnt1, 3'b010); chk("rot_sw21", sw1, 1'b1); end
            22: chk("rot_hex1", hex1, F1);
            36: chk("rot_g36", gnt1, 3'b010);
            37: chk("rot_g37", gnt1, 3'b000);
            41: chk("rot_g41", gnt1, 3'b001);
            default: ;
         endcase
      end
      chk("rot_onehot", bad, 0);

      // Owner drops after one tick: frozen frame until hold met, gap, then IDLE.
      do_reset(3'b001, 3'b000);
      while (k < 20) begin
         adv();
         case (k)
            3:  chk("drop_hex3", hex1, F0);
            4:  begin req1 = 3'b000; seg[55:0] = FB; end
            6:  begin chk("drop_frozen6", hex1, F0); chk("drop_g6", gnt1, 3'b001); end
            8:  begin chk("drop_frozen8", hex1, F0); chk("drop_g8", gnt1, 3'b001); end
            9:  begin chk("drop_g9", gnt1, 3'b000); chk("drop_gap_hex", hex1, BLANK); end
            13: begin chk("drop_idle_g", gnt1, 3'b000); chk("drop_idle_hex", hex1, BLANK);
                      chk("drop_idle_id", id1, 2'd0); end
            20: chk("drop_no_regrant", gnt1, 3'b000);
            default: ;
         endcase
      end
      seg[55:0] = F0;

      // Reset while owner 1 holds the display.
      do_reset(3'b111, 3'b000);
      while (k < 27) begin
         adv();
         case (k)
            24: begin chk("mid_rst_own1", gnt1, 3'b010); rst = 1'b1; end
            25: begin chk("mid_rst_g", gnt1, 3'b000); chk("mid_rst_id", id1, 2'd2);
                      chk("mid_rst_hex", hex1, BLANK); chk("mid_rst_sw", sw1, 1'b0);
                      rst = 1'b0; end
            26: begin chk("mid_rst_regrant", gnt1, 3'b001); chk("mid_rst_sw26", sw1, 1'b1); end
            default: ;
         endcase
      end

      // Direct handover with no gap.
      do_reset(3'b000, 3'b101);
      bad = 0;
      swcnt = 0;
      while (k < 33) begin
         adv();
         if (sw0) swcnt++;
         if (k >= 2 && hex0 == BLANK) bad = 1;
         case (k)
            1:  chk("dir_g1", gnt0, 3'b001);
            16: chk("dir_g16", gnt0, 3'b001);
            17: begin chk("dir_g17", gnt0, 3'b100); chk("dir_sw17", sw0, 1'b1);
                      chk("dir_hex17", hex0, F0); end
            18: chk("dir_hex18", hex0, F2);
            33: chk("dir_g33", gnt0, 3'b001);
            default: ;
         endcase
      end
      chk("dir_no_blank", bad, 0);
      chk("dir_sw_count", swcnt, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
